// File: rtl/sign_ext_pkg.sv
// Shared widths and a combinational sign-extension helper for the datapath.
package sign_ext_pkg;

    localparam int SIGNEX_IN_W  = 10;
    localparam int SIGNEX_OUT_W = 32;

    // Default-width helper for combinational users outside the registered unit.
    function automatic logic [SIGNEX_OUT_W-1:0] sign_extend(
        input logic [SIGNEX_IN_W-1:0] value
    );
        return {{(SIGNEX_OUT_W-SIGNEX_IN_W){value[SIGNEX_IN_W-1]}}, value};
    endfunction

endpackage

// File: rtl/sign_ext_core.sv
// Combinational sign extension of an IN_W-bit two's-complement field to OUT_W bits.
module sign_ext_core
    import sign_ext_pkg::*;
#(
    parameter int IN_W  = SIGNEX_IN_W,
    parameter int OUT_W = SIGNEX_OUT_W
) (
    input  logic [IN_W-1:0]  val_i,
    output logic [OUT_W-1:0] ext_o
);

    // A zero-width replication is illegal, so equal widths get a plain wire.
    generate
        if (OUT_W == IN_W) begin : g_pass
            assign ext_o = val_i;
        end else begin : g_ext
            assign ext_o = {{(OUT_W-IN_W){val_i[IN_W-1]}}, val_i};
        end
    endgenerate

endmodule

// File: rtl/sign_extender.sv
// Registered sign extender with a valid flag travelling alongside the data.
// Optional zero-extension select is enabled by defining SIGNEX_ZERO_MODE_EN.
module sign_extender
    import sign_ext_pkg::*;
#(
    parameter int IN_W  = SIGNEX_IN_W,
    parameter int OUT_W = SIGNEX_OUT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IN_W-1:0]  valin,
    input  logic             in_valid,
`ifdef SIGNEX_ZERO_MODE_EN
    input  logic             zero_ext,
`endif
    output logic [OUT_W-1:0] extended,
    output logic             out_valid
);

    // Valid-only handshake (no ready): a beat with in_valid=1 is always
    // accepted and appears one edge later with out_valid=1; otherwise the
    // data register holds and out_valid drops.

    generate
        if (IN_W < 2 || IN_W > OUT_W) begin : g_bad_params
            $error("sign_extender: requires 2 <= IN_W <= OUT_W");
        end
    endgenerate

    logic [OUT_W-1:0] sext_w;
    logic [OUT_W-1:0] word_w;
    logic [OUT_W-1:0] extended_q, extended_d;
    logic             out_valid_q, out_valid_d;

    sign_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .val_i (valin),
        .ext_o (sext_w)
    );

`ifdef SIGNEX_ZERO_MODE_EN
    always_comb begin
        word_w = sext_w;
        if (zero_ext) begin
            word_w = OUT_W'(valin);
        end
    end
`else
    assign word_w = sext_w;
`endif

    always_comb begin
        extended_d  = extended_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            extended_d = word_w;
        end
    end

    // Reset wins over a coincident valid beat; that beat is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            extended_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            extended_q  <= extended_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign extended  = extended_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_sign_extender.sv
// Directed bench for sign_extender, including 16->32 and 32->32 parameterisations.
// Zero-extension cases are exercised when SIGNEX_ZERO_MODE_EN is defined.
module tb_sign_extender;

    logic        clk;
    logic        reset;
    logic [9:0]  valin;
    logic        in_valid;
    logic [31:0] extended;
    logic        out_valid;

    logic [15:0] valin16;
    logic        in_valid16;
    logic [31:0] extended16;
    logic        out_valid16;

    logic [31:0] valin32;
    logic        in_valid32;
    logic [31:0] extended32;
    logic        out_valid32;

`ifdef SIGNEX_ZERO_MODE_EN
    logic        zero_ext;
`endif

    int errors;
    int checks;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sign_extender dut (
        .clk       (clk),
        .reset     (reset),
        .valin     (valin),
        .in_valid  (in_valid),
`ifdef SIGNEX_ZERO_MODE_EN
        .zero_ext  (zero_ext),
`endif
        .extended  (extended),
        .out_valid (out_valid)
    );

    sign_extender #(.IN_W(16), .OUT_W(32)) dut16 (
        .clk       (clk),
        .reset     (reset),
        .valin     (valin16),
        .in_valid  (in_valid16),
`ifdef SIGNEX_ZERO_MODE_EN
        .zero_ext  (1'b0),
`endif
        .extended  (extended16),
        .out_valid (out_valid16)
    );

    sign_extender #(.IN_W(32), .OUT_W(32)) dut32 (
        .clk       (clk),
        .reset     (reset),
        .valin     (valin32),
        .in_valid  (in_valid32),
`ifdef SIGNEX_ZERO_MODE_EN
        .zero_ext  (1'b0),
`endif
        .extended  (extended32),
        .out_valid (out_valid32)
    );

    // Advance one rising edge and settle so outputs are sampled off the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        in_valid   = 1'b0;
        valin      = 10'h155;
        in_valid16 = 1'b0;
        valin16    = 16'h0;
        in_valid32 = 1'b0;
        valin32    = 32'h0;
`ifdef SIGNEX_ZERO_MODE_EN
        zero_ext   = 1'b0;
`endif
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (extended !== 32'h0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got ext=%h v=%b, want ext=00000000 v=0", i, extended, out_valid);
            end
        end
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (extended !== 32'h0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_release[%0d]: got ext=%h v=%b, want ext=00000000 v=0", i, extended, out_valid);
            end
        end
    endtask

    task automatic test_stream();
        logic [9:0]  vin [7];
        logic [31:0] vexp [7];
        vin  = '{10'b1000000000, 10'b0000000001, 10'b1001100010, 10'b0111111111,
                 10'b1010101110, 10'b0000010000, 10'b1111111111};
        vexp = '{32'hFFFFFE00, 32'h00000001, 32'hFFFFFE62, 32'h000001FF,
                 32'hFFFFFEAE, 32'h00000010, 32'hFFFFFFFF};
        for (int i = 0; i < 7; i++) begin
            valin    = vin[i];
            in_valid = 1'b1;
            step();
            checks++;
            if (extended !== vexp[i] || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL stream[%0d] in=%b: got ext=%h v=%b, want ext=%h v=1", i, vin[i], extended, out_valid, vexp[i]);
            end
        end
        in_valid = 1'b0;
        valin    = 10'h0;
        step();
        // Zero input with valid: must overwrite the previous all-ones result.
        in_valid = 1'b1;
        step();
        checks++;
        if (extended !== 32'h0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL stream_zero: got ext=%h v=%b, want ext=00000000 v=1", extended, out_valid);
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_hold();
        valin    = 10'h2AE;
        in_valid = 1'b1;
        step();
        checks++;
        if (extended !== 32'hFFFFFEAE || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL hold_load: got ext=%h v=%b, want ext=fffffeae v=1", extended, out_valid);
        end
        valin    = 10'h001;
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (extended !== 32'hFFFFFEAE || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL hold_idle[%0d]: got ext=%h v=%b, want ext=fffffeae v=0", i, extended, out_valid);
            end
        end
    endtask

    task automatic test_reset_collision();
        reset    = 1'b1;
        valin    = 10'h3FF;
        in_valid = 1'b1;
        step();
        checks++;
        if (extended !== 32'h0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_collision: got ext=%h v=%b, want ext=00000000 v=0", extended, out_valid);
        end
        reset = 1'b0;
        valin = 10'h155;
        step();
        checks++;
        if (extended !== 32'h00000155 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_first: got ext=%h v=%b, want ext=00000155 v=1", extended, out_valid);
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_zero_mode();
`ifdef SIGNEX_ZERO_MODE_EN
        valin    = 10'h200;
        zero_ext = 1'b1;
        in_valid = 1'b1;
        step();
        checks++;
        if (extended !== 32'h00000200 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL zero_ext_on: got ext=%h v=%b, want ext=00000200 v=1", extended, out_valid);
        end
        zero_ext = 1'b0;
        step();
        checks++;
        if (extended !== 32'hFFFFFE00 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL zero_ext_off: got ext=%h v=%b, want ext=fffffe00 v=1", extended, out_valid);
        end
        in_valid = 1'b0;
        step();
`endif
    endtask

    task automatic test_param_sweep();
        valin16    = 16'h8001;
        in_valid16 = 1'b1;
        valin32    = 32'hDEADBEEF;
        in_valid32 = 1'b1;
        step();
        checks++;
        if (extended16 !== 32'hFFFF8001 || out_valid16 !== 1'b1) begin
            errors++;
            $display("FAIL w16_neg: got ext=%h v=%b, want ext=ffff8001 v=1", extended16, out_valid16);
        end
        checks++;
        if (extended32 !== 32'hDEADBEEF || out_valid32 !== 1'b1) begin
            errors++;
            $display("FAIL w32_pass_a: got ext=%h v=%b, want ext=deadbeef v=1", extended32, out_valid32);
        end
        valin16 = 16'h7FFF;
        valin32 = 32'h12345678;
        step();
        checks++;
        if (extended16 !== 32'h00007FFF || out_valid16 !== 1'b1) begin
            errors++;
            $display("FAIL w16_pos: got ext=%h v=%b, want ext=00007fff v=1", extended16, out_valid16);
        end
        checks++;
        if (extended32 !== 32'h12345678 || out_valid32 !== 1'b1) begin
            errors++;
            $display("FAIL w32_pass_b: got ext=%h v=%b, want ext=12345678 v=1", extended32, out_valid32);
        end
        in_valid16 = 1'b0;
        in_valid32 = 1'b0;
        step();
        checks++;
        if (extended16 !== 32'h00007FFF || out_valid16 !== 1'b0) begin
            errors++;
            $display("FAIL w16_hold: got ext=%h v=%b, want ext=00007fff v=0", extended16, out_valid16);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_stream();
        test_hold();
        test_reset_collision();
        test_zero_mode();
        test_param_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
